// File: rtl/seq_pat_pkg.sv
// Shared definitions for the serial pattern detector.
//   DEF_PAT_W : default maximum pattern length in bits
//   DEF_CNT_W : default match-counter width in bits
//   state_e   : detector FSM states
//                 IDLE - no pattern loaded
//                 FILL - fewer than pat_len bits of history
//                 RUN  - at least pat_len bits of history
package seq_pat_pkg;

    localparam int unsigned DEF_PAT_W = 8;
    localparam int unsigned DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset (count -> 0)
//   inc   : increment request; ignored once the count is all-ones
//   clr   : synchronous clear; wins over a simultaneous inc
//   count : current count value
//   sat   : high while count is all-ones
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign sat   = &count_q;
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !sat) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with a programmable pattern and saturating match counter.
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   din_valid   : qualifies din; one bit consumed per qualified cycle
//   din         : serial data bit
//   pat_load    : one-cycle strobe capturing pat_value / pat_len / overlap_en
//   pat_value   : pattern, bit pat_len-1 is received first, bit 0 last
//   pat_len     : pattern length (valid range 2..PAT_W)
//   overlap_en  : 1 = overlapping matches, 0 = history restarts after a match
//   cnt_clr     : synchronous clear of match_count / count_sat
//   match       : one-cycle pulse, one clock after the completing bit
//   match_count : saturating match count
//   count_sat   : high while match_count is all-ones
//   armed       : high while a valid pattern is loaded
//   cfg_err     : sticky flag for a rejected pat_load
module seq_pattern_detector
    import seq_pat_pkg::*;
#(
    parameter int unsigned PAT_W = DEF_PAT_W,
    parameter int unsigned CNT_W = DEF_CNT_W,
    localparam int unsigned LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din_valid,
    input  logic             din,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_value,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap_en,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat,
    output logic             armed,
    output logic             cfg_err
);

    state_e           state_q, state_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic             ovl_q, ovl_d;
    logic             match_q, match_d;
    logic             cfg_err_q, cfg_err_d;

    logic             load_ok;
    logic             consume;
    logic             hit;
    logic [PAT_W-1:0] len_mask;
    logic [PAT_W-1:0] hist_shift;
    logic [LEN_W-1:0] fill_inc;

    assign load_ok = pat_load && (pat_len >= LEN_W'(2)) && (pat_len <= LEN_W'(PAT_W));

    // A valid load in the same cycle discards the incoming bit.
    assign consume = din_valid && (state_q != IDLE) && !load_ok;

    // Only the low len_q bits of history and pattern take part in the compare.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < int'(PAT_W); i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
    end

    assign hist_shift = {hist_q[PAT_W-2:0], din};
    assign fill_inc   = (fill_q == len_q) ? fill_q : fill_q + LEN_W'(1);

    // fill saturates at len_q, so equality is the "enough history" condition.
    assign hit = (((hist_shift ^ pat_q) & len_mask) == '0) && (fill_inc == len_q);

    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        pat_d     = pat_q;
        len_d     = len_q;
        fill_d    = fill_q;
        ovl_d     = ovl_q;
        cfg_err_d = cfg_err_q;
        match_d   = 1'b0;

        if (load_ok) begin
            state_d   = FILL;
            hist_d    = '0;
            fill_d    = '0;
            pat_d     = pat_value;
            len_d     = pat_len;
            ovl_d     = overlap_en;
            cfg_err_d = 1'b0;
        end else begin
            if (pat_load) begin
                cfg_err_d = 1'b1;
            end
            if (consume) begin
                hist_d  = hist_shift;
                fill_d  = fill_inc;
                match_d = hit;
                if (hit && !ovl_q) begin
                    // Restart so the matched bits cannot contribute again.
                    fill_d  = '0;
                    state_d = FILL;
                end else if (fill_inc == len_q) begin
                    state_d = RUN;
                end else begin
                    state_d = FILL;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            hist_q    <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            fill_q    <= '0;
            ovl_q     <= 1'b0;
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            fill_q    <= fill_d;
            ovl_q     <= ovl_d;
            match_q   <= match_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign match   = match_q;
    assign armed   = (state_q != IDLE);
    assign cfg_err = cfg_err_q;

    // The counter advances on the edge that ends the match pulse, so a cnt_clr
    // raised alongside the pulse takes precedence over that match.
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match_q),
        .clr   (cnt_clr),
        .count (match_count),
        .sat   (count_sat)
    );

endmodule

// File: tb/tb_seq_pattern_detector.sv
module tb_seq_pattern_detector;

    localparam int unsigned PW = 8;
    localparam int unsigned LW = $clog2(PW + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          din_valid = 1'b0;
    logic          din = 1'b0;
    logic          pat_load = 1'b0;
    logic [PW-1:0] pat_value = '0;
    logic [LW-1:0] pat_len = '0;
    logic          overlap_en = 1'b0;
    logic          cnt_clr = 1'b0;

    logic          match, count_sat, armed, cfg_err;
    logic [7:0]    match_count;
    logic          match_s, count_sat_s, armed_s, cfg_err_s;
    logic [1:0]    match_count_s;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    seq_pattern_detector #(.PAT_W(PW), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .din_valid(din_valid), .din(din), .pat_load(pat_load),
        .pat_value(pat_value), .pat_len(pat_len), .overlap_en(overlap_en), .cnt_clr(cnt_clr),
        .match(match), .match_count(match_count), .count_sat(count_sat), .armed(armed),
        .cfg_err(cfg_err)
    );

    seq_pattern_detector #(.PAT_W(PW), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .din_valid(din_valid), .din(din), .pat_load(pat_load),
        .pat_value(pat_value), .pat_len(pat_len), .overlap_en(overlap_en), .cnt_clr(cnt_clr),
        .match(match_s), .match_count(match_count_s), .count_sat(count_sat_s), .armed(armed_s),
        .cfg_err(cfg_err_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: the bits seen since the last (re)start, trimmed to pat_len.
    bit          m_armed;
    bit          m_cfg_err;
    int          m_len;
    bit [PW-1:0] m_pat;
    bit          m_ovl;
    bit          m_q[$];
    bit          m_match;
    int          m_c8;
    int          m_c2;

    function automatic bit window_hit();
        if (m_q.size() != m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            if (m_q[i] != m_pat[m_len-1-i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_armed = 0; m_cfg_err = 0; m_len = 0; m_pat = '0; m_ovl = 0;
            m_q.delete(); m_match = 0; m_c8 = 0; m_c2 = 0;
        end else begin
            bit nxt;
            nxt = 0;
            if (cnt_clr) begin
                m_c8 = 0; m_c2 = 0;
            end else if (m_match) begin
                if (m_c8 < 255) m_c8++;
                if (m_c2 < 3) m_c2++;
            end
            if (pat_load && int'(pat_len) >= 2 && int'(pat_len) <= int'(PW)) begin
                m_armed = 1; m_cfg_err = 0; m_len = int'(pat_len);
                m_pat = pat_value; m_ovl = overlap_en; m_q.delete();
            end else begin
                if (pat_load) m_cfg_err = 1;
                if (m_armed && din_valid) begin
                    m_q.push_back(din);
                    if (m_q.size() > m_len) void'(m_q.pop_front());
                    if (window_hit()) begin
                        nxt = 1;
                        if (!m_ovl) m_q.delete();
                    end
                end
            end
            m_match = nxt;
        end
    end

    always @(negedge clk) begin
        check("match", 32'(match), 32'(m_match));
        check("match_s", 32'(match_s), 32'(m_match));
        check("count", 32'(match_count), 32'(m_c8));
        check("sat", 32'(count_sat), 32'(m_c8 == 255));
        check("count_s", 32'(match_count_s), 32'(m_c2));
        check("sat_s", 32'(count_sat_s), 32'(m_c2 == 3));
        check("armed", 32'(armed), 32'(m_armed));
        check("armed_s", 32'(armed_s), 32'(m_armed));
        check("cfg_err", 32'(cfg_err), 32'(m_cfg_err));
        check("cfg_err_s", 32'(cfg_err_s), 32'(m_cfg_err));
    end

    task automatic step();
        @(posedge clk);
        #1;
        pat_load = 1'b0;
        cnt_clr = 1'b0;
        din_valid = 1'b0;
    endtask

    task automatic bit_in(input logic b);
        din_valid = 1'b1;
        din = b;
        step();
    endtask

    task automatic load(input logic [PW-1:0] v, input int len, input logic ovl);
        pat_load = 1'b1;
        pat_value = v;
        pat_len = LW'(len);
        overlap_en = ovl;
        step();
    endtask

    task automatic clr();
        cnt_clr = 1'b1;
        step();
    endtask

    initial begin
        repeat (2) step();
        check("rst_armed", 32'(armed), 0);
        check("rst_count", 32'(match_count), 0);
        reset = 1'b0;
        step();

        // IDLE ignores data
        bit_in(1); bit_in(1); bit_in(0);
        check("idle_match", 32'(match), 0);

        // Rejected loads from IDLE and while armed
        load(8'h06, 1, 1);
        check("bad_from_idle_err", 32'(cfg_err), 1);
        check("bad_from_idle_armed", 32'(armed), 0);
        load(8'h06, 3, 1);
        check("good_load_err", 32'(cfg_err), 0);
        check("good_load_armed", 32'(armed), 1);
        bit_in(1); bit_in(1);
        load(8'hff, 1, 0);
        check("bad1_err", 32'(cfg_err), 1);
        load(8'hff, PW + 1, 0);
        check("bad9_err", 32'(cfg_err), 1);
        check("bad9_armed", 32'(armed), 1);
        bit_in(0);
        check("cfg_kept_match", 32'(match), 1);
        load(8'h03, 2, 1);
        check("reload_err", 32'(cfg_err), 0);
        bit_in(1);
        check("fill_nomatch", 32'(match), 0);
        bit_in(1);
        check("len2_match", 32'(match), 1);

        // 110 overlapping over 1101101001
        clr();
        load(8'h06, 3, 1);
        bit_in(1); bit_in(1); bit_in(0);
        check("p110_pulse3", 32'(match), 1);
        bit_in(1);
        check("p110_gap4", 32'(match), 0);
        bit_in(1); bit_in(0);
        check("p110_pulse6", 32'(match), 1);
        bit_in(1); bit_in(0); bit_in(0); bit_in(1);
        step(); step();
        check("p110_count", 32'(match_count), 2);

        // 101 over 10101, with and without overlap
        clr();
        load(8'h05, 3, 1);
        bit_in(1); bit_in(0); bit_in(1); bit_in(0); bit_in(1);
        step(); step();
        check("p101_ovl_count", 32'(match_count), 2);
        clr();
        load(8'h05, 3, 0);
        bit_in(1); bit_in(0); bit_in(1); bit_in(0); bit_in(1);
        step(); step();
        check("p101_novl_count", 32'(match_count), 1);

        // Saturation in the 2-bit counter and clear against a live match
        clr();
        load(8'h06, 3, 0);
        repeat (3) begin bit_in(1); bit_in(1); bit_in(0); end
        step();
        check("sat3_count", 32'(match_count_s), 3);
        check("sat3_flag", 32'(count_sat_s), 1);
        repeat (2) begin bit_in(1); bit_in(1); bit_in(0); end
        step();
        check("sat5_count", 32'(match_count_s), 3);
        bit_in(1); bit_in(1); bit_in(0);
        cnt_clr = 1'b1;
        check("clr_match", 32'(match_s), 1);
        step();
        check("clr_count", 32'(match_count_s), 0);
        check("clr_flag", 32'(count_sat_s), 0);

        // Gaps inside the pattern, then reset mid-pattern
        clr();
        load(8'h06, 3, 1);
        bit_in(1); step(); bit_in(1); step(); step(); bit_in(0);
        check("gap_match", 32'(match), 1);
        step();
        check("gap_nomatch", 32'(match), 0);
        step();
        check("gap_count", 32'(match_count), 1);
        bit_in(1); bit_in(1);
        #1 reset = 1'b1;
        #1;
        check("async_armed", 32'(armed), 0);
        check("async_count", 32'(match_count), 0);
        check("async_match", 32'(match), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        bit_in(0);
        check("post_rst_match", 32'(match), 0);
        load(8'h06, 3, 1);
        bit_in(0);
        check("post_rst_reload", 32'(match), 0);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            din_valid = ($urandom_range(3) != 0);
            din = 1'($urandom_range(1));
            cnt_clr = ($urandom_range(49) == 0);
            if ($urandom_range(24) == 0) begin
                int r;
                pat_load = 1'b1;
                overlap_en = 1'($urandom_range(1));
                pat_value = PW'($urandom);
                r = $urandom_range(9);
                if (r == 0) begin
                    int b;
                    b = $urandom_range(2);
                    pat_len = (b == 0) ? LW'(0) : (b == 1) ? LW'(1) : LW'(PW + 1);
                    din_valid = 1'b0;
                end else if (r < 7) begin
                    pat_len = LW'($urandom_range(3, 2));
                end else begin
                    pat_len = LW'($urandom_range(PW, 4));
                end
            end
            if ($urandom_range(599) == 0) reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            pat_load = 1'b0;
            cnt_clr = 1'b0;
            din_valid = 1'b0;
        end

        step(); step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
